// File: rtl/rr_arbiter_8.sv
// rr_arbiter_8: round-robin arbiter for 8 requesters with release, request-drop and hold-time revocation
module rr_arbiter_8 #(
    parameter int N_REQ    = 8,
    parameter int MAX_HOLD = 15
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req,
    input  logic             relinquish,
    output logic [N_REQ-1:0] grant,
    output logic [2:0]       grant_idx,
    output logic             grant_valid,
    output logic             timeout,
    output logic             busy
);
    localparam int HW = MAX_HOLD > 0 ? $clog2(MAX_HOLD + 1) : 1;

    typedef enum logic [1:0] {IDLE, GRANTED, RECOVER} state_t;

    state_t           state, state_n;
    logic [2:0]       ptr, ptr_n, idx_n, win_idx;
    logic [HW-1:0]    hold_cnt, hold_n;
    logic [N_REQ-1:0] grant_n, rot, first;
    logic             valid_n, timeout_n, limit, done;

    function automatic logic [2:0] enc8(input logic [7:0] v);
        return {v[4] | v[5] | v[6] | v[7], v[2] | v[3] | v[6] | v[7], v[1] | v[3] | v[5] | v[7]};
    endfunction

    // rot[0] is the requester at ptr, so the lowest set bit of rot is the round-robin winner
    always_comb begin
        for (int i = 0; i < N_REQ; i++) rot[i] = req[ptr + 3'(i)];
        first     = rot & (~rot + 1'b1);
        win_idx   = ptr + enc8(first);
        limit     = MAX_HOLD != 0 && hold_cnt == HW'(MAX_HOLD - 1);
        done      = relinquish || !req[grant_idx] || limit;
        state_n   = state;
        ptr_n     = ptr;
        hold_n    = '0;
        grant_n   = grant;
        idx_n     = grant_idx;
        valid_n   = grant_valid;
        timeout_n = 1'b0;
        if (state == GRANTED) begin
            hold_n    = hold_cnt == HW'(MAX_HOLD) ? hold_cnt : hold_cnt + 1'b1;
            state_n   = done ? RECOVER : GRANTED;
            ptr_n     = done ? grant_idx + 3'd1 : ptr;
            grant_n   = done ? '0 : grant;
            idx_n     = done ? 3'd0 : grant_idx;
            valid_n   = !done;
            timeout_n = done && limit && !relinquish && req[grant_idx];
        end else begin
            state_n = |req ? GRANTED : IDLE;
            grant_n = |req ? N_REQ'(1) << win_idx : '0;
            idx_n   = |req ? win_idx : 3'd0;
            valid_n = |req;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            ptr         <= '0;
            hold_cnt    <= '0;
            grant       <= '0;
            grant_idx   <= '0;
            grant_valid <= 1'b0;
            timeout     <= 1'b0;
            busy        <= 1'b0;
        end else begin
            state       <= state_n;
            ptr         <= ptr_n;
            hold_cnt    <= hold_n;
            grant       <= grant_n;
            grant_idx   <= idx_n;
            grant_valid <= valid_n;
            timeout     <= timeout_n;
            busy        <= state_n != IDLE;
        end
    end
endmodule

// File: tb/tb_rr_arbiter_8.sv
// tb_rr_arbiter_8: directed tenures queued as expectations, checked by a negedge monitor
module tb_rr_arbiter_8;
    logic       clk, rst, relinquish, grant_valid, timeout, busy;
    logic [7:0] req, grant;
    logic [2:0] grant_idx;

    typedef struct {
        int idx;
        int len;
        bit to;
        int gap;
        bit cut;
    } exp_t;

    exp_t sb[$];
    exp_t cur;
    int   total = 0, bad = 0;
    int   len = 0, gap = 0;
    bit   in_ten = 0, fell;

    rr_arbiter_8 #(.N_REQ(8), .MAX_HOLD(15)) dut (
        .clk(clk), .rst(rst), .req(req), .relinquish(relinquish),
        .grant(grant), .grant_idx(grant_idx), .grant_valid(grant_valid),
        .timeout(timeout), .busy(busy)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s got=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int idx, input int l, input bit to, input int g, input bit cut);
        exp_t e;
        e.idx = idx; e.len = l; e.to = to; e.gap = g; e.cut = cut;
        sb.push_back(e);
    endtask

    task automatic wait_grant();
        int n = 0;
        while (!grant_valid && n < 40) begin
            tick();
            n++;
        end
        if (!grant_valid) chk("wait_grant_timeout", 0, 1);
    endtask

    task automatic drain();
        int n = 0;
        do begin
            @(negedge clk);
            #1;
            n++;
        end while ((sb.size() != 0 || in_ten) && n < 100);
        if (sb.size() != 0 || in_ten) chk("drain_timeout", sb.size(), 0);
    endtask

    task automatic do_reset();
        rst = 1;
        tick();
        tick();
        rst = 0;
    endtask

    always @(negedge clk) begin
        fell = 0;
        chk("grant_onehot", int'(grant), grant_valid ? (1 << grant_idx) : 0);
        if (!grant_valid) chk("idx_zero", int'(grant_idx), 0);
        if (grant_valid && !in_ten) begin
            if (sb.size() == 0) begin
                chk("unexpected_grant", int'(grant_idx), -1);
                cur.idx = int'(grant_idx); cur.len = -1; cur.to = 0; cur.gap = -1; cur.cut = 0;
            end else begin
                cur = sb.pop_front();
                chk("grant_idx", int'(grant_idx), cur.idx);
                if (cur.gap >= 0) chk("gap", gap, cur.gap);
            end
            in_ten = 1;
            len = 1;
        end else if (grant_valid) begin
            len++;
        end else if (in_ten) begin
            chk("cut_by_reset", int'(rst), int'(cur.cut));
            if (!rst) begin
                if (cur.len >= 0) chk("tenure_len", len, cur.len);
                chk("timeout_pulse", int'(timeout), int'(cur.to));
                chk("busy_recover", int'(busy), 1);
            end
            in_ten = 0;
            gap = 1;
            fell = 1;
        end else begin
            gap++;
        end
        if (!fell) chk("timeout_quiet", int'(timeout), 0);
    end

    initial begin
        rst = 1; req = 0; relinquish = 0;
        #12;
        chk("rst_grant", int'(grant), 0);
        chk("rst_idx", int'(grant_idx), 0);
        chk("rst_valid", int'(grant_valid), 0);
        chk("rst_timeout", int'(timeout), 0);
        chk("rst_busy", int'(busy), 0);
        tick();
        rst = 0;

        // single request, released after one cycle
        push(2, 1, 0, -1, 0);
        req = 8'b0000_0100;
        wait_grant();
        relinquish = 1;
        tick();
        relinquish = 0;
        req = 0;
        chk("t1_valid_rec", int'(grant_valid), 0);
        chk("t1_busy_rec", int'(busy), 1);
        tick();
        chk("t1_busy_idle", int'(busy), 0);
        drain();

        // two requesters alternate with one idle cycle between tenures
        do_reset();
        push(1, 1, 0, -1, 0);
        push(4, 1, 0, 1, 0);
        push(1, 1, 0, 1, 0);
        req = 8'b0001_0010;
        for (int i = 0; i < 3; i++) begin
            wait_grant();
            if (i == 2) req = 0;
            relinquish = 1;
            tick();
            relinquish = 0;
        end
        drain();

        // hold timeout, pointer wraps from 7 back to 0
        do_reset();
        push(6, 15, 1, -1, 0);
        push(7, 15, 1, 1, 0);
        push(6, 15, 1, 1, 0);
        req = 8'b1100_0000;
        drain();
        req = 0;
        tick();
        tick();

        // owner drops its request, next arbitration picks idx5
        do_reset();
        push(3, 3, 0, -1, 0);
        push(5, 1, 0, 1, 0);
        req = 8'b0010_1000;
        wait_grant();
        tick();
        tick();
        req = 8'b0010_0000;
        tick();
        chk("t4_valid_rec", int'(grant_valid), 0);
        wait_grant();
        relinquish = 1;
        req = 0;
        tick();
        relinquish = 0;
        drain();

        // release coinciding with the hold limit is a normal end
        do_reset();
        push(0, 15, 0, -1, 0);
        req = 8'b0000_0001;
        wait_grant();
        repeat (14) tick();
        relinquish = 1;
        req = 0;
        tick();
        relinquish = 0;
        chk("t5_timeout", int'(timeout), 0);
        drain();

        // asynchronous reset mid-tenure
        do_reset();
        push(2, -1, 0, -1, 1);
        push(0, 1, 0, -1, 0);
        req = 8'b0000_0100;
        wait_grant();
        tick();
        tick();
        #2;
        rst = 1;
        #1;
        chk("t6_grant", int'(grant), 0);
        chk("t6_valid", int'(grant_valid), 0);
        chk("t6_busy", int'(busy), 0);
        req = 8'b1000_0001;
        tick();
        tick();
        rst = 0;
        wait_grant();
        relinquish = 1;
        req = 0;
        tick();
        relinquish = 0;
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
